// File: rtl/nd_2to1_if.sv
// rtl/nd_2to1_if.sv - handshake bundle between the 2-to-1 merge node and its neighbours
interface nd_2to1_if #(
  parameter int ASZ = 6,
  parameter int DSZ = 4,
  parameter int RSZ = 4
);
  localparam int MSZ = 2 * ASZ + DSZ + RSZ;

  logic           gch_ready;
  logic           rcv0_req;
  logic           rcv0_ack;
  logic [MSZ-1:0] rcv0_data;
  logic           rcv1_req;
  logic           rcv1_ack;
  logic [MSZ-1:0] rcv1_data;
  logic           snd0_req;
  logic           snd0_ack;
  logic [MSZ-1:0] snd0_data;

  // master: the surrounding network (sources and sink); slave: the node
  modport master (
    output rcv0_req, rcv0_data, rcv1_req, rcv1_data, snd0_ack,
    input  gch_ready, rcv0_ack, rcv1_ack, snd0_req, snd0_data
  );

  modport slave (
    input  rcv0_req, rcv0_data, rcv1_req, rcv1_data, snd0_ack,
    output gch_ready, rcv0_ack, rcv1_ack, snd0_req, snd0_data
  );
endinterface

// File: rtl/nd_2to1.sv
// rtl/nd_2to1.sv - two-input round-robin merge node with one message buffer per input
module nd_2to1 #(
  parameter int ASZ = 6,
  parameter int DSZ = 4,
  parameter int RSZ = 4
) (
  input  logic     gch_clk,
  input  logic     gch_reset,
  nd_2to1_if.slave bus
);
  localparam int MSZ = 2 * ASZ + DSZ + RSZ;

  typedef enum logic {R_IDLE, R_WAIT} r_state_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} s_state_t;

  logic           ready_q;
  r_state_t       r_state_q [2];
  r_state_t       r_state_d [2];
  logic [MSZ-1:0] mbuf_q [2];
  logic [MSZ-1:0] mbuf_d [2];
  logic [1:0]     full_q, full_d;
  s_state_t       s_state_q, s_state_d;
  logic           sel_q, sel_d;
  logic           rr_q, rr_d;
  logic [MSZ-1:0] snd_data_q, snd_data_d;

  logic [1:0]     rcv_req;
  logic [MSZ-1:0] rcv_data [2];

  assign rcv_req     = {bus.rcv1_req, bus.rcv0_req};
  assign rcv_data[0] = bus.rcv0_data;
  assign rcv_data[1] = bus.rcv1_data;

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      ready_q      <= 1'b0;
      r_state_q[0] <= R_IDLE;
      r_state_q[1] <= R_IDLE;
      mbuf_q[0]    <= '0;
      mbuf_q[1]    <= '0;
      full_q       <= 2'b00;
      s_state_q    <= S_IDLE;
      sel_q        <= 1'b0;
      rr_q         <= 1'b0;
      snd_data_q   <= '0;
    end else begin
      ready_q    <= 1'b1;
      r_state_q  <= r_state_d;
      mbuf_q     <= mbuf_d;
      full_q     <= full_d;
      s_state_q  <= s_state_d;
      sel_q      <= sel_d;
      rr_q       <= rr_d;
      snd_data_q <= snd_data_d;
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    mbuf_d     = mbuf_q;
    full_d     = full_q;
    s_state_d  = s_state_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    snd_data_d = snd_data_q;

    // A full buffer withholds ack, which is the only backpressure a source sees
    for (int i = 0; i < 2; i++) begin
      case (r_state_q[i])
        R_IDLE: begin
          if (rcv_req[i] && !full_q[i] && ready_q) begin
            mbuf_d[i]    = rcv_data[i];
            full_d[i]    = 1'b1;
            r_state_d[i] = R_WAIT;
          end
        end
        R_WAIT: begin
          if (!rcv_req[i]) begin
            r_state_d[i] = R_IDLE;
          end
        end
        default: r_state_d[i] = R_IDLE;
      endcase
    end

    case (s_state_q)
      S_IDLE: begin
        if (|full_q) begin
          // Pointer always ends up aimed away from whoever was just served
          sel_d      = (full_q == 2'b11) ? rr_q : full_q[1];
          rr_d       = ~sel_d;
          snd_data_d = mbuf_q[sel_d];
          s_state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.snd0_ack) begin
          full_d[sel_q] = 1'b0;
          s_state_d     = S_ACK;
        end
      end
      S_ACK: begin
        if (!bus.snd0_ack) begin
          s_state_d = S_IDLE;
        end
      end
      default: s_state_d = S_IDLE;
    endcase
  end

  assign bus.gch_ready = ready_q;
  assign bus.rcv0_ack  = (r_state_q[0] == R_WAIT);
  assign bus.rcv1_ack  = (r_state_q[1] == R_WAIT);
  assign bus.snd0_req  = (s_state_q == S_REQ);
  assign bus.snd0_data = snd_data_q;
endmodule
